// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V pipeline register file.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  typedef logic [4:0]      reg_idx_t;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/wr_counter.sv
// Saturating up/down outstanding-write counter for one architectural register.
module wr_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] MAX = '1;

  assign ovf = inc && !dec && !clr && (cnt == MAX);

  // Underflow simply holds: leftover write-backs drain harmlessly after a flush.
  always_ff @(posedge clk or posedge srst) begin
    if (srst)                              cnt <= '0;
    else if (clr)                          cnt <= '0;
    else if (inc && !dec && cnt != MAX)    cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)     cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with write-through bypass and per-register pending-write scoreboard.
// Build option: REGFILE_RESET_CLEAR_EN makes srst also clear the data registers.
module reg_file_scoreboard
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            issue_valid_d,
  input  logic            issue_wr_d,
  input  reg_idx_t        issue_rd_d,
  input  logic            flush,
  input  reg_idx_t        a1_d,
  input  reg_idx_t        a2_d,
  input  logic            reg_write_w,
  input  reg_idx_t        rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [XLEN-1:0] rd1_d,
  output logic [XLEN-1:0] rd2_d,
  output logic            busy1_d,
  output logic            busy2_d,
  output logic            ovf_err
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] cnt  [NREGS];
  logic [NREGS-1:0] ovf;

`ifdef REGFILE_RESET_CLEAR_EN
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      regs[0] <= '0;
      for (int r = 1; r < NREGS; r++)
        if (reg_write_w && rd_w == reg_idx_t'(r)) regs[r] <= result_w;
    end
  end
`else
  always_ff @(posedge clk) begin
    regs[0] <= '0;
    for (int r = 1; r < NREGS; r++)
      if (reg_write_w && rd_w == reg_idx_t'(r)) regs[r] <= result_w;
  end
`endif

  // x0 is hard-wired: no counter, never busy.
  assign cnt[0] = '0;
  assign ovf[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    wr_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .srst (srst),
      .inc  (issue_valid_d && issue_wr_d && issue_rd_d == reg_idx_t'(r) && !flush),
      .dec  (reg_write_w && rd_w == reg_idx_t'(r)),
      .clr  (flush),
      .cnt  (cnt[r]),
      .ovf  (ovf[r])
    );
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst)      ovf_err <= 1'b0;
    else if (|ovf) ovf_err <= 1'b1;
  end

  logic byp1, byp2;
  assign byp1 = reg_write_w && rd_w == a1_d;
  assign byp2 = reg_write_w && rd_w == a2_d;

  assign rd1_d = (a1_d == '0) ? '0 : byp1 ? result_w : regs[a1_d];
  assign rd2_d = (a2_d == '0) ? '0 : byp2 ? result_w : regs[a2_d];

  // A write-back landing this cycle already retires one outstanding write.
  assign busy1_d = (a1_d != '0) && (cnt[a1_d] > (byp1 ? CNT_W'(1) : CNT_W'(0)));
  assign busy2_d = (a2_d != '0) && (cnt[a2_d] > (byp2 ? CNT_W'(1) : CNT_W'(0)));
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with a cycle-level reference model.
module tb_reg_file_scoreboard;
  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        issue_valid_d, issue_wr_d, flush, reg_write_w;
  logic [4:0]  issue_rd_d, a1_d, a2_d, rd_w;
  logic [31:0] result_w, rd1_d, rd2_d;
  logic        busy1_d, busy2_d, ovf_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .srst(srst), .issue_valid_d(issue_valid_d), .issue_wr_d(issue_wr_d),
    .issue_rd_d(issue_rd_d), .flush(flush), .a1_d(a1_d), .a2_d(a2_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .busy1_d(busy1_d), .busy2_d(busy2_d), .ovf_err(ovf_err)
  );

  // Reference model: architectural state as plain integers and arrays.
  int          m_cnt [32];
  logic [31:0] m_reg [32];
  bit          m_known [32];
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      m_ovf = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
`ifdef REGFILE_RESET_CLEAR_EN
        m_reg[r] = '0; m_known[r] = 1'b1;
`else
        m_known[r] = (r == 0); m_reg[r] = '0;
`endif
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        bit inc, dec;
        inc = issue_valid_d && issue_wr_d && issue_rd_d == r && !flush;
        dec = reg_write_w && rd_w == r;
        if (flush) m_cnt[r] = 0;
        else if (inc && !dec) begin
          if (m_cnt[r] == 3) m_ovf = 1'b1; else m_cnt[r]++;
        end else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
      end
      if (reg_write_w && rd_w != 0) begin
        m_reg[rd_w] = result_w; m_known[rd_w] = 1'b1;
      end
    end
  end

  function automatic bit exp_busy(input logic [4:0] a);
    int pend;
    pend = m_cnt[a] - ((reg_write_w && rd_w == a) ? 1 : 0);
    return (a != 0) && (pend > 0);
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (a1_d == 0) chk("rd1", rd1_d, 32'h0);
    else if (reg_write_w && rd_w == a1_d) chk("rd1_byp", rd1_d, result_w);
    else if (m_known[a1_d]) chk("rd1", rd1_d, m_reg[a1_d]);
    if (a2_d == 0) chk("rd2", rd2_d, 32'h0);
    else if (reg_write_w && rd_w == a2_d) chk("rd2_byp", rd2_d, result_w);
    else if (m_known[a2_d]) chk("rd2", rd2_d, m_reg[a2_d]);
    chk("busy1", busy1_d, exp_busy(a1_d));
    chk("busy2", busy2_d, exp_busy(a2_d));
    chk("ovf", ovf_err, m_ovf);
  end

  task automatic idle();
    issue_valid_d = 0; issue_wr_d = 0; issue_rd_d = 0; flush = 0;
    a1_d = 0; a2_d = 0; reg_write_w = 0; rd_w = 0; result_w = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid_d = 1; issue_wr_d = 1; issue_rd_d = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] v);
    reg_write_w = 1; rd_w = rd; result_w = v;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 srst = 0; a1_d = 5; #1;
`ifdef REGFILE_RESET_CLEAR_EN
    chk("reset_rd1", rd1_d, 32'h0);
`endif
    chk("reset_busy1", busy1_d, 1'b0);
    chk("reset_ovf", ovf_err, 1'b0);

    // Write then read, plus same-cycle bypass
    step(); idle(); wb(3, 32'hDEADBEEF); a2_d = 3; #1;
    chk("bypass_rd2", rd2_d, 32'hDEADBEEF);
    step(); idle(); a1_d = 3; #1;
    chk("readback_rd1", rd1_d, 32'hDEADBEEF);

    // Register 0
    step(); idle(); wb(0, 32'h1234); #1;
    chk("x0_same", rd1_d, 32'h0);
    step(); idle(); issue(0); #1;
    chk("x0_next", rd1_d, 32'h0);
    step(); idle(); #1;
    chk("x0_busy", busy1_d, 1'b0);

    // Saturation on register 7
    for (int i = 0; i < 3; i++) begin step(); idle(); issue(7); end
    step(); idle(); a1_d = 7; issue(7); #1;
    chk("r7_busy_cnt3", busy1_d, 1'b1);
    chk("r7_no_ovf_yet", ovf_err, 1'b0);
    step(); idle(); a1_d = 7; #1;
    chk("r7_ovf", ovf_err, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(); idle(); a1_d = 7; wb(7, 32'h700 + i); #1;
      chk("r7_drain_busy", busy1_d, (i < 2) ? 1'b1 : 1'b0);
    end
    step(); idle(); a1_d = 7; #1;
    chk("r7_idle", busy1_d, 1'b0);

    // Simultaneous issue and write-back on register 9
    step(); idle(); issue(9);
    step(); idle(); issue(9); wb(9, 32'h99); a1_d = 9;
    step(); idle(); a1_d = 9; #1;
    chk("r9_still_busy", busy1_d, 1'b1);
    step(); idle(); wb(9, 32'h9A);

    // Flush with counts 2 on r4, 1 on r6
    step(); idle(); issue(4);
    step(); idle(); issue(4);
    step(); idle(); issue(6);
    step(); idle(); a1_d = 4; a2_d = 6; #1;
    chk("pre_flush_b1", busy1_d, 1'b1);
    chk("pre_flush_b2", busy2_d, 1'b1);
    flush = 1;
    step(); idle(); a1_d = 4; a2_d = 6; #1;
    chk("post_flush_b1", busy1_d, 1'b0);
    chk("post_flush_b2", busy2_d, 1'b0);
    wb(4, 32'h55);
    step(); idle(); a1_d = 4; #1;
    chk("r4_data", rd1_d, 32'h55);
    chk("r4_busy", busy1_d, 1'b0);
    chk("ovf_sticky", ovf_err, 1'b1);

    // Flush together with a write-back
    issue(6);
    step(); idle(); flush = 1; wb(6, 32'h66);
    step(); idle(); a1_d = 6; #1;
    chk("r6_flush_wb_data", rd1_d, 32'h66);
    chk("r6_flush_wb_busy", busy1_d, 1'b0);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
